bias_pingpong_buffer: RTL and testbench
=======================================

BIAS_PINGPONG_BUFFER -- requirements
Module: bias_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 512, meaning bias word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 7, meaning per-bank address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter BE_W, default DATA_W/8, meaning host byte-enable width.
REQ-004 Clocking: one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-005 SHALL have these ports, one per line (name direction width meaning):
 i_clk  in  1  clock
 i_rst  in  1  sync active-high reset
 i_host_en  in  1  host port access enable
 i_host_we  in  1  host write enable
 i_host_be  in  BE_W  host byte enables
 i_host_addr  in  ADDR_W  host word address (fill bank)
 i_host_wdata  in  DATA_W  host write data
 o_host_rdata  out  DATA_W  host read data, fill bank
 i_swap_req  in  1  pulse: exchange fill/active banks
 o_swap_ack  out  1  pulse: swap performed
 o_active_bank  out  1  bank currently read by core
 i_rd_start  in  1  pulse: start stream read
 i_rd_base  in  ADDR_W  stream start address
 i_rd_len  in  ADDR_W+1  stream word count
 o_rd_busy  out  1  stream in progress
 o_dat  out  DATA_W  stream data
 o_dat_vld  out  1  stream data valid
 i_dat_rdy  in  1  consumer ready
 o_rd_done  out  1  pulse: last word accepted

Function
REQ-006 Two banks; host port SHALL access only bank ~o_active_bank, stream reads only bank o_active_bank.
REQ-007 Host write: when i_host_en & i_host_we, bytes with i_host_be[k]=1 SHALL be written at the edge; others unchanged.
REQ-008 Host read: when i_host_en & ~i_host_we, o_host_rdata SHALL show the addressed word one cycle later, then hold until the next host read.
REQ-009 Stream FSM states IDLE, STREAM, DRAIN: IDLE->STREAM on i_rd_start with i_rd_len!=0; STREAM->DRAIN after last SRAM read issued; DRAIN->IDLE when last word handshakes (o_dat_vld & i_dat_rdy).
REQ-010 Stream addresses SHALL be base, base+1, ... modulo 2^ADDR_W (wrap to 0).
REQ-011 i_rd_len=0 SHALL produce o_rd_done one cycle after i_rd_start, no data, FSM stays IDLE.
REQ-012 i_rd_start while o_rd_busy SHALL be ignored.
REQ-013 SRAM read latency 1 cycle; words SHALL go through a 2-entry skid FIFO; a read is issued only when FIFO occupancy + in-flight reads < 2, so no word is lost under any i_dat_rdy pattern.
REQ-014 With i_dat_rdy held high, first o_dat_vld SHALL occur 2 cycles after i_rd_start and then one word per cycle.
REQ-015 o_dat SHALL be stable while o_dat_vld & ~i_dat_rdy.
REQ-016 o_rd_busy SHALL be high from the cycle after accepted i_rd_start until the cycle o_rd_done pulses.
REQ-017 i_swap_req in IDLE SHALL toggle o_active_bank at the next edge and pulse o_swap_ack that cycle; during a stream it SHALL be held pending and performed the cycle after o_rd_done.
REQ-018 Host access coincident with swap SHALL target the pre-swap fill bank.
REQ-019 Swap coincident with i_rd_start in IDLE: swap SHALL take effect first; stream reads the new active bank.

Reset
REQ-020 i_rst SHALL set FSM=IDLE, o_active_bank=0, skid FIFO empty, pending swap cleared, and o_dat_vld, o_rd_busy, o_rd_done, o_swap_ack=0; o_host_rdata, o_dat=0.
REQ-021 Reset mid-stream SHALL abort the stream with no o_rd_done; SRAM contents SHALL be preserved.

Structure
REQ-022 Package npu_bias_pkg SHALL hold the FSM state type and default DATA_W/ADDR_W constants.
REQ-023 Skid FIFO SHALL be sub-module bias_skid_fifo (2 entries, valid/ready both sides).

Verification
REQ-024 Host writes 0xA5.. to fill-bank addr 3 with be=all-ones, swap, stream base=3 len=1 -> o_dat=0xA5.. 2 cycles after start, o_rd_done next handshake.
REQ-025 Byte-enable: write all-ones, then zeros with be=0x1 at addr 5 -> host read addr 5 shows byte0=0x00, others 0xFF.
REQ-026 Wrap: base=126 len=4, depth 128 -> words from addrs 126,127,0,1 in order.
REQ-027 Backpressure: len=8, i_dat_rdy random 50% -> exactly 8 words, in order, o_dat stable while stalled.
REQ-028 Swap during stream: i_swap_req at word 2 of len=6 -> o_active_bank unchanged until cycle after o_rd_done, o_swap_ack one pulse.
REQ-029 Reset asserted mid-stream -> o_dat_vld=0, o_rd_busy=0 next cycle, no o_rd_done, prior SRAM data readable afterward.

Source files
------------

// File: rtl/npu_bias_pkg.sv
// Shared types and default sizing for the NPU bias ping-pong buffer.
// Holds the stream FSM state type and the default word/address widths.
package npu_bias_pkg;

    localparam int BIAS_DATA_W = 512;
    localparam int BIAS_ADDR_W = 7;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/bias_skid_fifo.sv
// Two-entry registered skid FIFO between the bias SRAM read port and the core.
// The head entry drives the output directly, so the output holds while stalled.
module bias_skid_fifo
    import npu_bias_pkg::*;
#(
    parameter int DATA_W = BIAS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_s_vld,
    input  logic [DATA_W-1:0] i_s_dat,
    output logic              o_s_rdy,
    output logic              o_m_vld,
    output logic [DATA_W-1:0] o_m_dat,
    input  logic              i_m_rdy,
    output logic [1:0]        o_count
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic              push, pop;

    assign o_s_rdy = (count_q != 2'd2) || i_m_rdy;
    assign o_m_vld = (count_q != 2'd0);
    assign o_m_dat = ent0_q;
    assign o_count = count_q;

    always_comb begin
        push    = i_s_vld && o_s_rdy;
        pop     = o_m_vld && i_m_rdy;
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = i_s_dat;
                else                 ent1_d = i_s_dat;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = i_s_dat;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = i_s_dat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ent1_q <= ent1_d;
    end

endmodule

// File: rtl/bias_pingpong_buffer.sv
// Double-banked bias store: the host fills one bank while the core streams the other.
// Banks exchange on a swap request, deferred until any running stream has finished.
module bias_pingpong_buffer
    import npu_bias_pkg::*;
#(
    parameter int DATA_W = BIAS_DATA_W,
    parameter int ADDR_W = BIAS_ADDR_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_host_en,
    input  logic              i_host_we,
    input  logic [BE_W-1:0]   i_host_be,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_active_bank,
    input  logic              i_rd_start,
    input  logic [ADDR_W-1:0] i_rd_base,
    input  logic [ADDR_W:0]   i_rd_len,
    output logic              o_rd_busy,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_dat_vld,
    input  logic              i_dat_rdy,
    output logic              o_rd_done
);

    localparam int DEPTH = 1 << ADDR_W;

    // Bank select is the MSB of the flat index: {bank, addr}.
    logic [DATA_W-1:0] mem_q [0:2*DEPTH-1];

    rd_state_e         state_q, state_d;
    logic              active_bank_q, active_bank_d;
    logic              swap_pend_q, swap_pend_d;
    logic              swap_ack_q, swap_ack_d;
    logic              rd_done_q, rd_done_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic [ADDR_W:0]   acc_left_q, acc_left_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic              rd_issue;
    logic [ADDR_W-1:0] rd_issue_addr;
    logic              swap_now;
    logic              credit;
    logic [2:0]        occ_sum;
    logic              fifo_in_rdy, fifo_vld, fifo_pop;
    logic [1:0]        fifo_count;

    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
        end
        return res;
    endfunction

    bias_skid_fifo #(.DATA_W(DATA_W)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_s_vld (inflight_q),
        .i_s_dat (rd_data_q),
        .o_s_rdy (fifo_in_rdy),
        .o_m_vld (fifo_vld),
        .o_m_dat (o_dat),
        .i_m_rdy (i_dat_rdy),
        .o_count (fifo_count)
    );

    assign fifo_pop = fifo_vld && i_dat_rdy;
    assign occ_sum  = {1'b0, fifo_count} + {2'b00, inflight_q};
    // A same-cycle pop frees a slot, which is what sustains one word per cycle.
    assign credit   = (occ_sum < 3'd2) || (fifo_pop && (occ_sum < 3'd3));

    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        swap_pend_d   = swap_pend_q;
        swap_ack_d    = 1'b0;
        rd_done_d     = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_left_d     = rd_left_q;
        acc_left_d    = acc_left_q;
        rd_issue      = 1'b0;
        rd_issue_addr = rd_addr_q;
        swap_now      = 1'b0;

        case (state_q)
            RD_IDLE: begin
                swap_now = i_swap_req || swap_pend_q;
                if (i_rd_start) begin
                    if (i_rd_len == '0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_issue      = 1'b1;
                        rd_issue_addr = i_rd_base;
                        rd_addr_d     = i_rd_base + 1'b1;
                        rd_left_d     = i_rd_len - 1'b1;
                        acc_left_d    = i_rd_len;
                        state_d       = RD_STREAM;
                    end
                end
            end
            RD_STREAM: begin
                if (i_swap_req) swap_pend_d = 1'b1;
                if (rd_left_q == '0) begin
                    state_d = RD_DRAIN;
                end else if (credit && fifo_in_rdy) begin
                    rd_issue  = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == (ADDR_W+1)'(1)) state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (i_swap_req) swap_pend_d = 1'b1;
            end
            default: state_d = RD_IDLE;
        endcase

        if ((state_q != RD_IDLE) && fifo_pop) begin
            acc_left_d = acc_left_q - 1'b1;
            if (acc_left_q == (ADDR_W+1)'(1)) begin
                rd_done_d = 1'b1;
                state_d   = RD_IDLE;
            end
        end

        if (swap_now) begin
            active_bank_d = ~active_bank_q;
            swap_pend_d   = 1'b0;
            swap_ack_d    = 1'b1;
        end

        // Stream reads use the post-swap bank so a coincident swap+start reads the new bank.
        inflight_d = rd_issue;
        rd_data_d  = rd_data_q;
        if (rd_issue) rd_data_d = mem_q[{active_bank_d, rd_issue_addr}];

        host_rdata_d = host_rdata_q;
        if (i_host_en && !i_host_we) host_rdata_d = mem_q[{~active_bank_q, i_host_addr}];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= RD_IDLE;
            active_bank_q <= 1'b0;
            swap_pend_q   <= 1'b0;
            swap_ack_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            inflight_q    <= 1'b0;
            rd_addr_q     <= '0;
            rd_left_q     <= '0;
            acc_left_q    <= '0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            swap_pend_q   <= swap_pend_d;
            swap_ack_q    <= swap_ack_d;
            rd_done_q     <= rd_done_d;
            inflight_q    <= inflight_d;
            rd_addr_q     <= rd_addr_d;
            rd_left_q     <= rd_left_d;
            acc_left_q    <= acc_left_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        rd_data_q <= rd_data_d;
    end

    // Host writes always land in the fill bank as seen before any coincident swap.
    always_ff @(posedge i_clk) begin
        if (i_host_en && i_host_we) begin
            mem_q[{~active_bank_q, i_host_addr}] <=
                be_merge(mem_q[{~active_bank_q, i_host_addr}], i_host_wdata, i_host_be);
        end
    end

    assign o_host_rdata  = host_rdata_q;
    assign o_swap_ack    = swap_ack_q;
    assign o_active_bank = active_bank_q;
    assign o_rd_busy     = (state_q != RD_IDLE);
    assign o_rd_done     = rd_done_q;
    assign o_dat_vld     = fifo_vld;

endmodule

// File: tb/tb_bias_pingpong_buffer.sv
// Directed bench for bias_pingpong_buffer: host fill, swaps, streams, backpressure, reset.
// Expected words come from the pat() generator and hand-written constants.
module tb_bias_pingpong_buffer;

    localparam int DW = 512;
    localparam int AW = 7;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_host_en, i_host_we;
    logic [BW-1:0] i_host_be;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wdata, o_host_rdata;
    logic          i_swap_req, o_swap_ack, o_active_bank;
    logic          i_rd_start;
    logic [AW-1:0] i_rd_base;
    logic [AW:0]   i_rd_len;
    logic          o_rd_busy;
    logic [DW-1:0] o_dat;
    logic          o_dat_vld, i_dat_rdy, o_rd_done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] got_q[$];
    int done_cnt, stable_err, first_cyc, last_cyc;

    always #5 clk = ~clk;

    bias_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_host_en    (i_host_en),
        .i_host_we    (i_host_we),
        .i_host_be    (i_host_be),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata),
        .o_host_rdata (o_host_rdata),
        .i_swap_req   (i_swap_req),
        .o_swap_ack   (o_swap_ack),
        .o_active_bank(o_active_bank),
        .i_rd_start   (i_rd_start),
        .i_rd_base    (i_rd_base),
        .i_rd_len     (i_rd_len),
        .o_rd_busy    (o_rd_busy),
        .o_dat        (o_dat),
        .o_dat_vld    (o_dat_vld),
        .i_dat_rdy    (i_dat_rdy),
        .o_rd_done    (o_rd_done)
    );

    function automatic logic [DW-1:0] pat(input logic b, input int a);
        logic [7:0] ab;
        ab = 8'(a);
        return {16{{7'd0, b}, ab, 16'hBEEF}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        i_host_en = 1'b1; i_host_we = 1'b1; i_host_addr = AW'(a);
        i_host_wdata = d; i_host_be = be;
        step();
        i_host_en = 1'b0; i_host_we = 1'b0;
    endtask

    task automatic host_read(input int a);
        i_host_en = 1'b1; i_host_we = 1'b0; i_host_addr = AW'(a);
        step();
        i_host_en = 1'b0;
    endtask

    // Launches a stream and records accepted words until o_rd_done (or a cycle budget).
    task automatic run_stream(input int base, input int len, input bit rand_rdy);
        logic [DW-1:0] hold_dat;
        bit stalled;
        got_q.delete();
        done_cnt = 0; stable_err = 0; first_cyc = -1; last_cyc = -1;
        stalled = 1'b0; hold_dat = '0;
        i_rd_base = AW'(base); i_rd_len = (AW+1)'(len);
        i_rd_start = 1'b1; i_dat_rdy = 1'b1;
        step();
        i_rd_start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (o_rd_done) begin
                done_cnt++;
                break;
            end
            if (stalled && (!o_dat_vld || o_dat !== hold_dat)) stable_err++;
            i_dat_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_dat_vld && i_dat_rdy) begin
                got_q.push_back(o_dat);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            stalled  = o_dat_vld && !i_dat_rdy;
            hold_dat = o_dat;
            step();
        end
        i_dat_rdy = 1'b1;
        step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_host_en = 0; i_host_we = 0; i_host_be = '0; i_host_addr = '0; i_host_wdata = '0;
        i_swap_req = 0; i_rd_start = 0; i_rd_base = '0; i_rd_len = '0; i_dat_rdy = 1;
        repeat (3) step();
        checks++; if (o_active_bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", o_active_bank); end
        checks++; if (o_dat_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_dat_vld); end
        checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_rd_busy); end
        checks++; if (o_rd_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_rd_done); end
        checks++; if (o_swap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", o_swap_ack); end
        checks++; if (o_host_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", o_host_rdata); end
        checks++; if (o_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", o_dat); end
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] exp;
        exp = {{(BW-1){8'hFF}}, 8'h00};
        host_write(5, {DW{1'b1}}, {BW{1'b1}});
        host_write(5, '0, BW'(1));
        host_read(5);
        checks++; if (o_host_rdata !== exp) begin errors++; $display("FAIL be_read: got %h want %h", o_host_rdata, exp); end
        host_write(6, '0, {BW{1'b1}});
        step();
        checks++; if (o_host_rdata !== exp) begin errors++; $display("FAIL be_hold: got %h want %h", o_host_rdata, exp); end
    endtask

    task automatic test_basic_stream();
        for (int a = 0; a < 128; a++) host_write(a, pat(1'b1, a), {BW{1'b1}});
        host_write(3, {BW{8'hA5}}, {BW{1'b1}});
        i_swap_req = 1'b1;
        step();
        i_swap_req = 1'b0;
        checks++; if (o_swap_ack !== 1'b1) begin errors++; $display("FAIL swap_ack: got %b want 1", o_swap_ack); end
        checks++; if (o_active_bank !== 1'b1) begin errors++; $display("FAIL swap_bank: got %b want 1", o_active_bank); end
        step();
        checks++; if (o_swap_ack !== 1'b0) begin errors++; $display("FAIL swap_ack_pulse: got %b want 0", o_swap_ack); end
        i_rd_base = AW'(3); i_rd_len = (AW+1)'(1); i_rd_start = 1'b1; i_dat_rdy = 1'b1;
        step();
        i_rd_start = 1'b0;
        checks++; if (o_rd_busy !== 1'b1 || o_dat_vld !== 1'b0) begin errors++; $display("FAIL basic_c1: got busy=%b vld=%b want busy=1 vld=0", o_rd_busy, o_dat_vld); end
        step();
        checks++; if (o_dat_vld !== 1'b1) begin errors++; $display("FAIL basic_vld_c2: got %b want 1", o_dat_vld); end
        checks++; if (o_dat !== {BW{8'hA5}}) begin errors++; $display("FAIL basic_dat: got %h want %h", o_dat, {BW{8'hA5}}); end
        step();
        checks++; if (o_rd_done !== 1'b1 || o_rd_busy !== 1'b0 || o_dat_vld !== 1'b0) begin
            errors++; $display("FAIL basic_done: got done=%b busy=%b vld=%b want 1 0 0", o_rd_done, o_rd_busy, o_dat_vld); end
        step();
        checks++; if (o_rd_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", o_rd_done); end
    endtask

    task automatic test_len_zero();
        i_rd_base = AW'(9); i_rd_len = '0; i_rd_start = 1'b1;
        step();
        i_rd_start = 1'b0;
        checks++; if (o_rd_done !== 1'b1 || o_rd_busy !== 1'b0 || o_dat_vld !== 1'b0) begin
            errors++; $display("FAIL len0: got done=%b busy=%b vld=%b want 1 0 0", o_rd_done, o_rd_busy, o_dat_vld); end
        step();
        checks++; if (o_rd_done !== 1'b0 || o_dat_vld !== 1'b0) begin errors++; $display("FAIL len0_after: got done=%b vld=%b want 0 0", o_rd_done, o_dat_vld); end
    endtask

    task automatic test_wrap();
        int addrs [4] = '{126, 127, 0, 1};
        logic [DW-1:0] act;
        run_stream(126, 4, 1'b0);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (act !== pat(1'b1, addrs[i])) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", i, act, pat(1'b1, addrs[i])); end
        end
        checks++; if (first_cyc != 2 || last_cyc != 5) begin errors++; $display("FAIL wrap_timing: got first=%0d last=%0d want 2 5", first_cyc, last_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
        checks++; if (o_rd_done !== 1'b0) begin errors++; $display("FAIL wrap_done_pulse: got %b want 0", o_rd_done); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] act;
        run_stream(10, 8, 1'b1);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (act !== pat(1'b1, 10 + i)) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, act, pat(1'b1, 10 + i)); end
        end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_swap_during_stream();
        int nwords, done_cyc, ack_cnt, ack_cyc, bank_err;
        logic [DW-1:0] act;
        for (int a = 40; a < 48; a++) host_write(a, pat(1'b0, a), {BW{1'b1}});
        got_q.delete();
        nwords = 0; done_cyc = -1; ack_cnt = 0; ack_cyc = -1; bank_err = 0;
        i_rd_base = AW'(20); i_rd_len = (AW+1)'(6); i_rd_start = 1'b1; i_dat_rdy = 1'b1;
        step();
        i_rd_start = 1'b0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            i_swap_req = 1'b0; i_rd_start = 1'b0;
            if (o_swap_ack) begin ack_cnt++; ack_cyc = cyc; end
            if (done_cyc < 0 && o_active_bank !== 1'b1) bank_err++;
            if (o_rd_done) done_cyc = cyc;
            if (o_dat_vld) begin
                got_q.push_back(o_dat);
                nwords++;
                if (nwords == 3) begin
                    i_swap_req = 1'b1;
                    i_rd_start = 1'b1; i_rd_base = '0; i_rd_len = (AW+1)'(3);
                end
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            step();
        end
        i_swap_req = 1'b0; i_rd_start = 1'b0;
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL swp_count: got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (act !== pat(1'b1, 20 + i)) begin errors++; $display("FAIL swp_word%0d: got %h want %h", i, act, pat(1'b1, 20 + i)); end
        end
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL swp_done_cyc: got %0d want 8", done_cyc); end
        checks++; if (bank_err != 0) begin errors++; $display("FAIL swp_bank_early: got %0d bad cycles want 0", bank_err); end
        checks++; if (ack_cnt != 1 || ack_cyc != done_cyc + 1) begin
            errors++; $display("FAIL swp_ack: got count=%0d cyc=%0d want 1 at %0d", ack_cnt, ack_cyc, done_cyc + 1); end
        checks++; if (o_active_bank !== 1'b0 || o_rd_busy !== 1'b0) begin
            errors++; $display("FAIL swp_final: got bank=%b busy=%b want 0 0", o_active_bank, o_rd_busy); end
    endtask

    task automatic test_reset_mid_stream();
        int done_seen, vld_seen;
        logic [DW-1:0] act;
        i_rd_base = AW'(40); i_rd_len = (AW+1)'(8); i_rd_start = 1'b1; i_dat_rdy = 1'b1;
        step();
        i_rd_start = 1'b0;
        repeat (3) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        checks++; if (o_dat_vld !== 1'b0 || o_rd_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got vld=%b busy=%b want 0 0", o_dat_vld, o_rd_busy); end
        done_seen = 0; vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_rd_done) done_seen++;
            if (o_dat_vld) vld_seen++;
            step();
        end
        checks++; if (done_seen != 0 || vld_seen != 0) begin
            errors++; $display("FAIL rst_quiet: got done=%0d vld=%0d want 0 0", done_seen, vld_seen); end
        checks++; if (o_host_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", o_host_rdata); end
        host_read(10);
        checks++; if (o_host_rdata !== pat(1'b1, 10)) begin errors++; $display("FAIL rst_keep_fill: got %h want %h", o_host_rdata, pat(1'b1, 10)); end
        run_stream(40, 2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            checks++; if (act !== pat(1'b0, 40 + i)) begin errors++; $display("FAIL rst_keep_act%0d: got %h want %h", i, act, pat(1'b0, 40 + i)); end
        end
    endtask

    task automatic test_swap_with_start();
        i_swap_req = 1'b1;
        i_rd_base = AW'(10); i_rd_len = (AW+1)'(1); i_rd_start = 1'b1; i_dat_rdy = 1'b1;
        step();
        i_swap_req = 1'b0; i_rd_start = 1'b0;
        checks++; if (o_swap_ack !== 1'b1 || o_active_bank !== 1'b1 || o_rd_busy !== 1'b1) begin
            errors++; $display("FAIL sws_c1: got ack=%b bank=%b busy=%b want 1 1 1", o_swap_ack, o_active_bank, o_rd_busy); end
        step();
        checks++; if (o_dat_vld !== 1'b1 || o_dat !== pat(1'b1, 10)) begin
            errors++; $display("FAIL sws_dat: got vld=%b dat=%h want 1 %h", o_dat_vld, o_dat, pat(1'b1, 10)); end
        step();
        checks++; if (o_rd_done !== 1'b1) begin errors++; $display("FAIL sws_done: got %b want 1", o_rd_done); end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_basic_stream();
        test_len_zero();
        test_wrap();
        test_backpressure();
        test_swap_during_stream();
        test_reset_mid_stream();
        test_swap_with_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
